// File: rtl/excp_trap_ctrl_if.sv
// -----------------------------------------------------------------------------
// excp_trap_ctrl_if
// Bundle of the handshake channels around the trap-entry sequencer:
//   - retiring-instruction channel (valid/ready plus pc, instr, badaddr and
//     the synchronous exception flags)
//   - single CSR write port (valid/ready, addr, data)
//   - pipeline flush channel (req/ack, redirect pc)
// Modports:
//   slave  : the trap controller's view (accepts retiring instructions,
//            issues CSR writes and flush requests)
//   master : the surrounding pipeline / CSR file view
// -----------------------------------------------------------------------------
interface excp_trap_ctrl_if #(
  parameter int XLEN = 32
);
  // retiring instruction channel
  logic            excp_i_valid;
  logic            excp_i_ready;
  logic [XLEN-1:0] excp_i_pc;
  logic [31:0]     excp_i_instr;
  logic [XLEN-1:0] excp_i_badaddr;
  logic            excp_i_ebreak;
  logic            excp_i_ecall;
  logic            excp_i_illegal;
  logic            excp_i_ld_misalign;
  logic            excp_i_st_misalign;

  // CSR write port
  logic            csr_wr_valid;
  logic [11:0]     csr_wr_addr;
  logic [XLEN-1:0] csr_wr_data;
  logic            csr_wr_ready;

  // pipeline flush
  logic            flush_req;
  logic [XLEN-1:0] flush_pc;
  logic            flush_ack;

  modport slave (
    input  excp_i_valid, excp_i_pc, excp_i_instr, excp_i_badaddr,
           excp_i_ebreak, excp_i_ecall, excp_i_illegal,
           excp_i_ld_misalign, excp_i_st_misalign,
    output excp_i_ready,
    output csr_wr_valid, csr_wr_addr, csr_wr_data,
    input  csr_wr_ready,
    output flush_req, flush_pc,
    input  flush_ack
  );

  modport master (
    output excp_i_valid, excp_i_pc, excp_i_instr, excp_i_badaddr,
           excp_i_ebreak, excp_i_ecall, excp_i_illegal,
           excp_i_ld_misalign, excp_i_st_misalign,
    input  excp_i_ready,
    input  csr_wr_valid, csr_wr_addr, csr_wr_data,
    output csr_wr_ready,
    input  flush_req, flush_pc,
    output flush_ack
  );
endinterface

// File: rtl/excp_trap_ctrl.sv
// -----------------------------------------------------------------------------
// excp_trap_ctrl
// Trap-entry sequencer for the execute/commit stage. On acceptance of a
// retiring instruction it arbitrates the external interrupt and the
// synchronous exception flags, captures pc/cause/mtval, then writes
// mepc, mcause, mtval and mstatus (one CSR per cycle through the single
// write port) and finally requests a pipeline flush to the trap vector.
// With HALT_ON_EBREAK set, a selected ebreak halts the core instead and
// latches a0 as the end code.
//
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   bus          : retiring-instruction / CSR write / flush channels (slave)
//   irq_ext      : external interrupt level
//   mstatus_i    : current mstatus
//   mie_meie     : MIE.MEIE
//   mtvec        : trap vector base / mode
//   a0_val       : x10, used as end code on halt
//   commit_trap  : one-cycle pulse when a trap or halt commits
//   cmt_cause    : cause of the last taken trap
//   halt         : core halted (sticky until reset)
//   endcode      : a0 value latched at halt
// -----------------------------------------------------------------------------
module excp_trap_ctrl #(
  parameter int XLEN           = 32,
  parameter bit HALT_ON_EBREAK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  excp_trap_ctrl_if.slave bus,
  input  logic            irq_ext,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic            mie_meie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] a0_val,
  output logic            commit_trap,
  output logic [XLEN-1:0] cmt_cause,
  output logic            halt,
  output logic [XLEN-1:0] endcode
);

  // Cause codes; the interrupt cause carries the MSB interrupt flag.
  localparam logic [XLEN-1:0] CAUSE_IRQ  = {1'b1, {(XLEN-5){1'b0}}, 4'd11};
  localparam logic [XLEN-1:0] CAUSE_BRK  = {{(XLEN-4){1'b0}}, 4'd3};
  localparam logic [XLEN-1:0] CAUSE_ILL  = {{(XLEN-4){1'b0}}, 4'd2};
  localparam logic [XLEN-1:0] CAUSE_ECL  = {{(XLEN-4){1'b0}}, 4'd11};
  localparam logic [XLEN-1:0] CAUSE_LDM  = {{(XLEN-4){1'b0}}, 4'd4};
  localparam logic [XLEN-1:0] CAUSE_STM  = {{(XLEN-4){1'b0}}, 4'd6};
  // Vectored-mode offset for the machine external interrupt (4 * 11).
  localparam logic [XLEN-1:0] IRQ_VEC_OFS = {{(XLEN-6){1'b0}}, 6'd44};

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_MEPC    = 3'd1,
    WR_MCAUSE  = 3'd2,
    WR_MTVAL   = 3'd3,
    WR_MSTATUS = 3'd4,
    FLUSH      = 3'd5,
    HALT       = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] endcode_q, endcode_d;
  logic            halt_entry_q, halt_entry_d;

  logic            irq_pend_s;
  logic            accept_s;
  logic            ready_s;
  logic            sel_valid_s;
  logic            sel_ebreak_s;
  logic [XLEN-1:0] sel_cause_s;
  logic [XLEN-1:0] sel_mtval_s;
  logic [XLEN-1:0] mstatus_new_s;
  logic [XLEN-1:0] vec_pc_s;
  logic            csr_valid_s;
  logic [11:0]     csr_addr_s;
  logic [XLEN-1:0] csr_data_s;
  logic            flush_req_s;
  logic [XLEN-1:0] flush_pc_s;
  logic            flush_commit_s;

  // Ready is forced low while reset is asserted, not only by the state.
  assign ready_s    = rst & (state_q == IDLE);
  assign irq_pend_s = irq_ext & mstatus_i[3] & mie_meie;
  assign accept_s   = bus.excp_i_valid & ready_s;

  // Priority selection of the trap cause and its mtval for the retiring instruction.
  always_comb begin
    sel_valid_s  = 1'b1;
    sel_ebreak_s = 1'b0;
    sel_cause_s  = {XLEN{1'b0}};
    sel_mtval_s  = {XLEN{1'b0}};
    if (irq_pend_s) begin
      sel_cause_s = CAUSE_IRQ;
    end else if (bus.excp_i_ebreak) begin
      sel_cause_s  = CAUSE_BRK;
      sel_ebreak_s = 1'b1;
    end else if (bus.excp_i_illegal) begin
      sel_cause_s = CAUSE_ILL;
      sel_mtval_s = {{(XLEN-32){1'b0}}, bus.excp_i_instr};
    end else if (bus.excp_i_ecall) begin
      sel_cause_s = CAUSE_ECL;
    end else if (bus.excp_i_ld_misalign) begin
      sel_cause_s = CAUSE_LDM;
      sel_mtval_s = bus.excp_i_badaddr;
    end else if (bus.excp_i_st_misalign) begin
      sel_cause_s = CAUSE_STM;
      sel_mtval_s = bus.excp_i_badaddr;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  // New mstatus value: MPIE takes MIE, MIE cleared, MPP set to machine mode.
  always_comb begin
    mstatus_new_s        = mstatus_i;
    mstatus_new_s[7]     = mstatus_i[3];
    mstatus_new_s[3]     = 1'b0;
    mstatus_new_s[12:11] = 2'b11;
  end

  // Trap vector target; only the external interrupt is offset in vectored mode.
  always_comb begin
    vec_pc_s = {mtvec[XLEN-1:2], 2'b00};
    if ((mtvec[1:0] == 2'b01) && cause_q[XLEN-1]) begin
      vec_pc_s = vec_pc_s + IRQ_VEC_OFS;
    end else begin
      vec_pc_s = {mtvec[XLEN-1:2], 2'b00};
    end
  end

  // Next-state logic and capture of the trap context on acceptance.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cause_d      = cause_q;
    mtval_d      = mtval_q;
    endcode_d    = endcode_q;
    halt_entry_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s && sel_valid_s) begin
          pc_d    = bus.excp_i_pc;
          cause_d = sel_cause_s;
          mtval_d = sel_mtval_s;
          if (sel_ebreak_s && HALT_ON_EBREAK) begin
            state_d      = HALT;
            halt_entry_d = 1'b1;
            endcode_d    = a0_val;
          end else begin
            state_d = WR_MEPC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_MEPC: begin
        if (bus.csr_wr_ready) begin
          state_d = WR_MCAUSE;
        end else begin
          state_d = WR_MEPC;
        end
      end
      WR_MCAUSE: begin
        if (bus.csr_wr_ready) begin
          state_d = WR_MTVAL;
        end else begin
          state_d = WR_MCAUSE;
        end
      end
      WR_MTVAL: begin
        if (bus.csr_wr_ready) begin
          state_d = WR_MSTATUS;
        end else begin
          state_d = WR_MTVAL;
        end
      end
      WR_MSTATUS: begin
        if (bus.csr_wr_ready) begin
          state_d = FLUSH;
        end else begin
          state_d = WR_MSTATUS;
        end
      end
      FLUSH: begin
        if (bus.flush_ack) begin
          state_d = IDLE;
        end else begin
          state_d = FLUSH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the current state and the captured context.
  always_comb begin
    csr_valid_s    = 1'b0;
    csr_addr_s     = 12'h000;
    csr_data_s     = {XLEN{1'b0}};
    flush_req_s    = 1'b0;
    flush_pc_s     = {XLEN{1'b0}};
    flush_commit_s = 1'b0;
    case (state_q)
      WR_MEPC: begin
        csr_valid_s = 1'b1;
        csr_addr_s  = ADDR_MEPC;
        csr_data_s  = {pc_q[XLEN-1:2], 2'b00};
      end
      WR_MCAUSE: begin
        csr_valid_s = 1'b1;
        csr_addr_s  = ADDR_MCAUSE;
        csr_data_s  = cause_q;
      end
      WR_MTVAL: begin
        csr_valid_s = 1'b1;
        csr_addr_s  = ADDR_MTVAL;
        csr_data_s  = mtval_q;
      end
      WR_MSTATUS: begin
        csr_valid_s = 1'b1;
        csr_addr_s  = ADDR_MSTATUS;
        csr_data_s  = mstatus_new_s;
      end
      FLUSH: begin
        flush_req_s    = 1'b1;
        flush_pc_s     = vec_pc_s;
        flush_commit_s = bus.flush_ack;
      end
      IDLE, HALT: begin
        csr_valid_s = 1'b0;
      end
      default: begin
        csr_valid_s = 1'b0;
      end
    endcase
  end

  // State and trap-context registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= {XLEN{1'b0}};
      cause_q      <= {XLEN{1'b0}};
      mtval_q      <= {XLEN{1'b0}};
      endcode_q    <= {XLEN{1'b0}};
      halt_entry_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cause_q      <= cause_d;
      mtval_q      <= mtval_d;
      endcode_q    <= endcode_d;
      halt_entry_q <= halt_entry_d;
    end
  end

  assign bus.excp_i_ready = ready_s;
  assign bus.csr_wr_valid = csr_valid_s;
  assign bus.csr_wr_addr  = csr_addr_s;
  assign bus.csr_wr_data  = csr_data_s;
  assign bus.flush_req    = flush_req_s;
  assign bus.flush_pc     = flush_pc_s;

  // A halt commits on its first cycle in HALT; a trap commits on flush ack.
  assign commit_trap = flush_commit_s | halt_entry_q;
  assign cmt_cause   = cause_q;
  assign halt        = (state_q == HALT);
  assign endcode     = endcode_q;

endmodule

// File: tb/tb_excp_trap_ctrl.sv
module tb_excp_trap_ctrl;
  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            irq_ext;
  logic [XLEN-1:0] mstatus_i;
  logic            mie_meie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] a0_val;
  logic            commit_trap;
  logic [XLEN-1:0] cmt_cause;
  logic            halt;
  logic [XLEN-1:0] endcode;

  int n_assert = 0;
  int n_fail   = 0;

  excp_trap_ctrl_if #(.XLEN(XLEN)) bus ();

  excp_trap_ctrl #(.XLEN(XLEN), .HALT_ON_EBREAK(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .irq_ext     (irq_ext),
    .mstatus_i   (mstatus_i),
    .mie_meie    (mie_meie),
    .mtvec       (mtvec),
    .a0_val      (a0_val),
    .commit_trap (commit_trap),
    .cmt_cause   (cmt_cause),
    .halt        (halt),
    .endcode     (endcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: first pending source in priority order decides cause/mtval.
  task automatic ref_trap(input bit irq_p, input logic [4:0] fl, input logic [31:0] instr,
                          input logic [XLEN-1:0] bad, output bit taken,
                          output logic [XLEN-1:0] cause, output logic [XLEN-1:0] mtval);
    bit              pend [6];
    logic [XLEN-1:0] cs   [6];
    logic [XLEN-1:0] tv   [6];
    pend = '{irq_p, fl[4], fl[3], fl[2], fl[1], fl[0]};
    cs   = '{32'h8000000B, 32'd3, 32'd2, 32'd11, 32'd4, 32'd6};
    tv   = '{32'd0, 32'd0, instr, 32'd0, bad, bad};
    taken = 1'b0;
    cause = 32'd0;
    mtval = 32'd0;
    for (int i = 5; i >= 0; i--) begin
      if (pend[i]) begin
        taken = 1'b1;
        cause = cs[i];
        mtval = tv[i];
      end
    end
  endtask

  function automatic logic [XLEN-1:0] ref_mstatus(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] mpie;
    mpie = (ms[3] == 1'b1) ? 32'h80 : 32'h0;
    return (ms & ~32'h0000_0088) | mpie | 32'h0000_1800;
  endfunction

  task automatic clear_inputs();
    bus.excp_i_valid       = 1'b0;
    bus.excp_i_ebreak      = 1'b0;
    bus.excp_i_illegal     = 1'b0;
    bus.excp_i_ecall       = 1'b0;
    bus.excp_i_ld_misalign = 1'b0;
    bus.excp_i_st_misalign = 1'b0;
  endtask

  // Drive one retiring instruction (flags = {ebreak,illegal,ecall,ldm,stm}) and
  // check the whole trap sequence. mode 0: ready/ack always 1, mode 1: ready
  // on the 4th cycle of each write, mode 2: random ready/ack.
  task automatic run_trap(input string nm, input logic [XLEN-1:0] pc, input logic [31:0] instr,
                          input logic [XLEN-1:0] bad, input logic [4:0] fl, input int mode,
                          input bit drop_irq);
    bit              irq_p, taken, done, held;
    logic [XLEN-1:0] cause, mtval, prev_cmt, exp_fpc, hold_data;
    logic [11:0]     exp_addr [4];
    logic [XLEN-1:0] exp_data [4];
    logic [11:0]     hold_addr;
    int              nw, stalls, cyc, wcnt;
    bit              rdy, ack;
    irq_p = irq_ext & mstatus_i[3] & mie_meie;
    ref_trap(irq_p, fl, instr, bad, taken, cause, mtval);
    exp_addr = '{12'h341, 12'h342, 12'h343, 12'h300};
    exp_data = '{pc & ~32'h3, cause, mtval, ref_mstatus(mstatus_i)};
    exp_fpc  = (mtvec & ~32'h3) + (((mtvec % 4) == 1 && irq_p) ? 32'd44 : 32'd0);
    prev_cmt = cmt_cause;

    chk({nm, "_idle_ready"}, {31'd0, bus.excp_i_ready}, 32'd1);
    bus.excp_i_valid       = 1'b1;
    bus.excp_i_pc          = pc;
    bus.excp_i_instr       = instr;
    bus.excp_i_badaddr     = bad;
    {bus.excp_i_ebreak, bus.excp_i_illegal, bus.excp_i_ecall,
     bus.excp_i_ld_misalign, bus.excp_i_st_misalign} = fl;
    @(negedge clk);
    clear_inputs();
    bus.excp_i_instr = $urandom;
    if (drop_irq) irq_ext = 1'b0;

    if (!taken) begin
      #1;
      chk({nm, "_ret_ready"}, {31'd0, bus.excp_i_ready}, 32'd1);
      chk({nm, "_ret_csr"}, {31'd0, bus.csr_wr_valid}, 32'd0);
      chk({nm, "_ret_flush"}, {31'd0, bus.flush_req}, 32'd0);
      chk({nm, "_ret_commit"}, {31'd0, commit_trap}, 32'd0);
      chk({nm, "_ret_cause"}, cmt_cause, prev_cmt);
      return;
    end

    chk({nm, "_cmt_cause"}, cmt_cause, cause);
    nw = 0; stalls = 0; cyc = 1; wcnt = 0; done = 1'b0; held = 1'b0;
    hold_addr = 12'h000; hold_data = 32'd0;
    while (!done && cyc < 200) begin
      case (mode)
        0: begin rdy = 1'b1; ack = 1'b1; end
        1: begin rdy = (wcnt == 3); ack = 1'b1; end
        default: begin rdy = ($urandom_range(0, 3) != 0); ack = ($urandom_range(0, 2) != 0); end
      endcase
      bus.csr_wr_ready = rdy;
      bus.flush_ack    = ack;
      #1;
      chk({nm, "_busy_ready"}, {31'd0, bus.excp_i_ready}, 32'd0);
      chk({nm, "_excl"}, {31'd0, bus.csr_wr_valid & bus.flush_req}, 32'd0);
      if (bus.csr_wr_valid) begin
        chk({nm, "_wr_commit"}, {31'd0, commit_trap}, 32'd0);
        if (held) begin
          chk({nm, "_hold_addr"}, {20'd0, bus.csr_wr_addr}, {20'd0, hold_addr});
          chk({nm, "_hold_data"}, bus.csr_wr_data, hold_data);
        end
        if (rdy) begin
          if (nw < 4) begin
            chk({nm, "_wr_addr"}, {20'd0, bus.csr_wr_addr}, {20'd0, exp_addr[nw]});
            chk({nm, "_wr_data"}, bus.csr_wr_data, exp_data[nw]);
          end else begin
            chk({nm, "_extra_wr"}, 32'd1, {28'd0, 4'(nw)});
          end
          nw++; held = 1'b0; wcnt = 0;
        end else begin
          held = 1'b1; hold_addr = bus.csr_wr_addr; hold_data = bus.csr_wr_data;
          stalls++; wcnt++;
        end
      end else if (bus.flush_req) begin
        chk({nm, "_nwrites"}, nw, 32'd4);
        chk({nm, "_flush_pc"}, bus.flush_pc, exp_fpc);
        if (ack) begin
          chk({nm, "_commit"}, {31'd0, commit_trap}, 32'd1);
          chk({nm, "_latency"}, cyc, 32'(5 + stalls));
          done = 1'b1;
        end else begin
          chk({nm, "_early_commit"}, {31'd0, commit_trap}, 32'd0);
          stalls++;
        end
      end else begin
        chk({nm, "_activity"}, {31'd0, bus.csr_wr_valid | bus.flush_req}, 32'd1);
        cyc = 200;
      end
      @(negedge clk);
      cyc++;
    end
    bus.csr_wr_ready = 1'b0;
    bus.flush_ack    = 1'b0;
    if (!done) chk({nm, "_timeout"}, 32'd0, 32'd1);
    #1;
    chk({nm, "_after_ready"}, {31'd0, bus.excp_i_ready}, 32'd1);
    chk({nm, "_after_commit"}, {31'd0, commit_trap}, 32'd0);
    chk({nm, "_after_cause"}, cmt_cause, cause);
  endtask

  initial begin
    rst = 1'b0;
    irq_ext = 1'b0; mstatus_i = 32'd0; mie_meie = 1'b0; mtvec = 32'd0; a0_val = 32'd0;
    clear_inputs();
    bus.excp_i_pc = 32'd0; bus.excp_i_instr = 32'd0; bus.excp_i_badaddr = 32'd0;
    bus.csr_wr_ready = 1'b0; bus.flush_ack = 1'b0;
    #12;
    // Reset state
    chk("rst_ready", {31'd0, bus.excp_i_ready}, 32'd0);
    chk("rst_csr_valid", {31'd0, bus.csr_wr_valid}, 32'd0);
    chk("rst_csr_addr", {20'd0, bus.csr_wr_addr}, 32'd0);
    chk("rst_csr_data", bus.csr_wr_data, 32'd0);
    chk("rst_flush_req", {31'd0, bus.flush_req}, 32'd0);
    chk("rst_flush_pc", bus.flush_pc, 32'd0);
    chk("rst_commit", {31'd0, commit_trap}, 32'd0);
    chk("rst_cause", cmt_cause, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_endcode", endcode, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Plain retirement for 10 cycles
    for (int i = 0; i < 10; i++) begin
      bus.excp_i_valid = 1'b1;
      bus.excp_i_pc    = $urandom;
      #1;
      chk("ret_ready", {31'd0, bus.excp_i_ready}, 32'd1);
      chk("ret_csr", {31'd0, bus.csr_wr_valid}, 32'd0);
      chk("ret_flush", {31'd0, bus.flush_req}, 32'd0);
      chk("ret_commit", {31'd0, commit_trap}, 32'd0);
      @(negedge clk);
    end
    clear_inputs();

    // ecall, zero-stall
    mtvec = 32'h8000_1000; mstatus_i = 32'h0000_0008;
    run_trap("ecall", 32'h8000_0104, 32'h0000_0073, 32'd0, 5'b00100, 0, 1'b0);

    // illegal + ld_misalign, 3 stall cycles per write
    run_trap("ill_ld", 32'h8000_0200, 32'hFFFF_FFFF, 32'h1234_5679, 5'b01010, 1, 1'b0);

    // interrupt beats ecall, vectored mtvec, irq drops after capture
    irq_ext = 1'b1; mie_meie = 1'b1; mstatus_i = 32'h0000_0008; mtvec = 32'h8000_1001;
    run_trap("irq", 32'h8000_0300, 32'h0000_0073, 32'd0, 5'b00100, 0, 1'b1);
    irq_ext = 1'b0;

    // Randomised traps/retirements against the reference model
    for (int i = 0; i < 30; i++) begin
      irq_ext   = 1'($urandom);
      mie_meie  = 1'($urandom);
      mstatus_i = $urandom;
      mtvec     = $urandom;
      run_trap("rnd", $urandom, $urandom, $urandom, 5'($urandom & 32'hF), 2, 1'($urandom));
      irq_ext = 1'b0;
    end

    // Reset asserted during WR_MCAUSE
    irq_ext = 1'b0; mstatus_i = 32'h8;
    bus.excp_i_valid = 1'b1; bus.excp_i_ecall = 1'b1; bus.excp_i_pc = 32'h8000_0400;
    bus.csr_wr_ready = 1'b1;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    bus.csr_wr_ready = 1'b0;
    #1;
    chk("mid_addr", {20'd0, bus.csr_wr_addr}, 32'h342);
    #2 rst = 1'b0;
    #1;
    chk("mid_csr_valid", {31'd0, bus.csr_wr_valid}, 32'd0);
    chk("mid_flush", {31'd0, bus.flush_req}, 32'd0);
    chk("mid_commit", {31'd0, commit_trap}, 32'd0);
    chk("mid_ready", {31'd0, bus.excp_i_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_ready", {31'd0, bus.excp_i_ready}, 32'd1);
      chk("post_csr", {31'd0, bus.csr_wr_valid}, 32'd0);
      chk("post_commit", {31'd0, commit_trap}, 32'd0);
      @(negedge clk);
    end

    // Halts: first with a non-zero end code, then after reset with a0=0
    for (int h = 0; h < 2; h++) begin
      a0_val = (h == 0) ? 32'hDEAD_BEEF : 32'd0;
      bus.excp_i_valid = 1'b1; bus.excp_i_ebreak = 1'b1; bus.excp_i_pc = 32'h8000_0500;
      @(negedge clk);
      clear_inputs();
      a0_val = $urandom;
      #1;
      chk("halt_commit", {31'd0, commit_trap}, 32'd1);
      chk("halt_flag", {31'd0, halt}, 32'd1);
      chk("halt_endcode", endcode, (h == 0) ? 32'hDEAD_BEEF : 32'd0);
      chk("halt_cause", cmt_cause, 32'd3);
      chk("halt_ready", {31'd0, bus.excp_i_ready}, 32'd0);
      bus.excp_i_valid = 1'b1; bus.excp_i_ecall = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        #1;
        chk("halt_pulse", {31'd0, commit_trap}, 32'd0);
        chk("halt_sticky", {31'd0, halt}, 32'd1);
        chk("halt_noready", {31'd0, bus.excp_i_ready}, 32'd0);
        chk("halt_nocsr", {31'd0, bus.csr_wr_valid | bus.flush_req}, 32'd0);
        chk("halt_cause_hold", cmt_cause, 32'd3);
      end
      clear_inputs();
      if (h == 0) begin
        rst = 1'b0;
        #1;
        chk("halt_rst_clear", {31'd0, halt}, 32'd0);
        chk("halt_rst_endcode", endcode, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/excp_trap_ctrl.md
Name: excp_trap_ctrl

Overview:
- Trap-entry sequencer for the NPC execute/commit stage.
- Arbitrates the synchronous exception sources of the retiring instruction and the external interrupt, then writes mepc/mcause/mtval/mstatus through the single CSR write port, one CSR per cycle.
- Then flushes the pipeline with a redirect to the trap vector.
- With HALT_ON_EBREAK set, ebreak instead halts the simulation core with an end code.

Parameters:
XLEN, 32, datapath width
HALT_ON_EBREAK, 1, 1: ebreak halts the core; 0: ebreak traps normally (cause 3)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
excp_i_valid  in  1  retiring instruction present
excp_i_ready  out  1  controller can accept
excp_i_pc  in  XLEN  pc of retiring instruction
excp_i_instr  in  32  instruction word
excp_i_badaddr  in  XLEN  faulting load/store address
excp_i_ebreak, excp_i_ecall, excp_i_illegal, excp_i_ld_misalign, excp_i_st_misalign  in  1 each  exception flags
irq_ext  in  1  external interrupt, level
mstatus_i  in  XLEN  current mstatus
mie_meie  in  1  MIE.MEIE
mtvec  in  XLEN  trap vector base/mode
a0_val  in  XLEN  x10 value, used as end code
csr_wr_valid  out  1  CSR write request
csr_wr_addr  out  12  CSR address
csr_wr_data  out  XLEN  CSR data
csr_wr_ready  in  1  CSR write accepted
flush_req  out  1  pipeline flush request
flush_pc  out  XLEN  redirect target
flush_ack  in  1  flush accepted
commit_trap  out  1  one-cycle pulse: trap/halt committed
cmt_cause  out  XLEN  last taken cause
halt  out  1  core halted (sticky)
endcode  out  XLEN  latched a0_val at halt

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, including cmt_cause, endcode, flush_pc, csr_wr_*. excp_i_ready=0 only while in reset.
- States: IDLE, WR_MEPC, WR_MCAUSE, WR_MTVAL, WR_MSTATUS, FLUSH, HALT.
- IDLE:
  - excp_i_ready=1.
  - Accept = excp_i_valid & excp_i_ready.
  - Interrupt pending = irq_ext & mstatus_i[3] & mie_meie.
- On accept, causes are evaluated with this priority:
  - interrupt (cause 0x8000000B, mtval 0)
  - ebreak (3, mtval 0)
  - illegal (2, mtval = instr zero-extended)
  - ecall (11, mtval 0)
  - ld_misalign (4, mtval = badaddr)
  - st_misalign (6, mtval = badaddr)
- Accept with no pending cause: normal retirement, stay IDLE, no outputs change.
- Accept with a cause: latch pc, cause and mtval. cmt_cause updates the next cycle.
  - ebreak as the selected cause with HALT_ON_EBREAK=1: go to HALT.
  - Otherwise: go to WR_MEPC.
- Inputs changing after capture (irq drop, flag change) have no effect on the sequence in progress.
- WR_* states:
  - csr_wr_valid=1 with the addresses and data below.
  - Hold addr/data stable until csr_wr_ready; advance on valid&ready.
  - WR_MEPC: addr 0x341, data = {pc[XLEN-1:2],2'b00}.
  - WR_MCAUSE: addr 0x342, data = cause.
  - WR_MTVAL: addr 0x343, data = mtval.
  - WR_MSTATUS: addr 0x300, data = mstatus_i with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11. mstatus_i is sampled in this state.
- FLUSH:
  - flush_req=1.
  - flush_pc = {mtvec[XLEN-1:2],2'b00}. When mtvec[1:0]==2'b01 and cause is an interrupt, add 4*11 (=44).
  - On flush_ack: commit_trap=1 for that cycle, next state IDLE.
  - flush_req and flush_pc hold until ack.
- HALT:
  - Entry cycle: commit_trap pulses 1 and endcode latches a0_val.
  - halt=1 from entry onward.
  - excp_i_ready=0, no CSR writes, no flush.
  - Sticky until reset.
- Minimum trap latency with csr_wr_ready=flush_ack=1: accept at T, writes at T+1..T+4, flush+commit_trap at T+5, excp_i_ready=1 at T+6.
- Handshake rule: excp_i_ready=0 in every state except IDLE; csr_wr_valid and flush_req are never asserted together.
- Async reset mid-sequence: return to IDLE immediately, drop csr_wr_valid/flush_req, no commit_trap.

Test Plan:
- Plain retirement: valid=1, no flags, irq=0 for 10 cycles -> ready=1 throughout, no csr_wr_valid/flush_req/commit_trap.
- ecall at pc 0x80000104, mtvec 0x80001000, ready/ack tied 1 -> writes 0x341=0x80000104, 0x342=11, 0x343=0, 0x300 with MIE cleared/MPIE set/MPP=3. Then flush_pc 0x80001000 with commit_trap at T+5; cmt_cause=11.
- illegal+ld_misalign together, instr 0xFFFFFFFF, csr_wr_ready low 3 cycles per write -> cause 2, mtval 0xFFFFFFFF, addr/data stable while stalled, commit_trap at T+17 (ready, and hence each write's acceptance, arrives on the 4th cycle of each write state).
- irq_ext=1, MIE=1, MEIE=1, with ecall flag, mtvec 0x80001001 -> cause 0x8000000B wins, mtval 0, flush_pc 0x8000102C. irq dropping mid-sequence does not change the sequence.
- ebreak, HALT_ON_EBREAK=1, a0_val=0 -> commit_trap one pulse, halt=1, endcode=0, cmt_cause=3, ready stays 0. A subsequent valid is never accepted.
- Assert rst during WR_MCAUSE -> csr_wr_valid drops immediately, state IDLE, ready=1 after release, no commit_trap.
